// File: rtl/clock_divider_mc_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Pure definitions: no latency and no flow control.
package clock_divider_mc_pkg;

    localparam int DIVW_DEF        = 16;
    localparam int DEFAULT_DIV_DEF = 2;
    localparam int MIN_DIV         = 1;

    // Per-channel registered status, packed so the top can unbundle it per bit.
    typedef struct packed {
        logic clk;
        logic tick;
        logic pending;
    } ch_out_t;

    // The channel index keeps at least one bit so a single-channel build still has a port.
    function automatic int ch_idx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/clock_divider_mc_if.sv
// Control/status bundle of the divider: enables, sync, divisor write and per-channel outputs.
// Wiring only: no latency and no backpressure.
interface clock_divider_mc_if #(
    parameter int NCH  = 4,
    parameter int DIVW = 16
);
    import clock_divider_mc_pkg::*;

    localparam int CHW = ch_idx_w(NCH);

    logic [NCH-1:0]  i_en;
    logic            i_sync;
    logic            i_wr_en;
    logic [CHW-1:0]  i_wr_ch;
    logic [DIVW-1:0] i_wr_div;
    logic [NCH-1:0]  o_clk;
    logic [NCH-1:0]  o_tick;
    logic [NCH-1:0]  o_pending;

    modport master (
        output i_en, i_sync, i_wr_en, i_wr_ch, i_wr_div,
        input  o_clk, o_tick, o_pending
    );

    modport slave (
        input  i_en, i_sync, i_wr_en, i_wr_ch, i_wr_div,
        output o_clk, o_tick, o_pending
    );

endinterface

// File: rtl/clock_divider_mc_ch.sv
// One divider channel: half-period counter, active/shadow divisor, clock, tick and pending flag.
// All outputs registered (1 cycle from inputs); no backpressure, writes always accepted.
module clock_divider_ch
    import clock_divider_mc_pkg::*;
#(
    parameter int DIVW        = DIVW_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic            i_sync,
    input  logic            i_wr,
    input  logic [DIVW-1:0] i_wr_div,
    output ch_out_t         o_st
);

    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] act_q, act_d;
    logic [DIVW-1:0] shd_q, shd_d;
    logic            clk_q, clk_d;
    logic            tick_q, tick_d;
    logic            pend_q, pend_d;

    logic [DIVW-1:0] half;
    logic            last;
    logic            running;
    logic            apply;

    always_comb begin
        half    = (act_q < DIVW'(MIN_DIV)) ? DIVW'(MIN_DIV) : act_q;
        last    = (cnt_q == half - DIVW'(1));
        running = i_en | clk_q;
        // Divisor may only change where no half-period is in flight: at the fall or while idle.
        apply   = i_sync | ~running | (last & clk_q);

        cnt_d  = cnt_q;
        act_d  = act_q;
        shd_d  = shd_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        pend_d = pend_q;

        if (i_wr) begin
            shd_d  = i_wr_div;
            pend_d = 1'b1;
        end
        if (apply) begin
            act_d  = i_wr ? i_wr_div : (pend_q ? shd_q : act_q);
            pend_d = 1'b0;
        end

        if (i_sync || !running) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (last) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
        end else begin
            cnt_d = cnt_q + DIVW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            act_q  <= DIVW'(DEFAULT_DIV);
            shd_q  <= DIVW'(DEFAULT_DIV);
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign o_st = {clk_q, tick_q, pend_q};

endmodule

// File: rtl/clock_divider_mc.sv
// NCH independent programmable clock dividers sharing one write port and one sync pulse.
// Outputs registered (1 cycle from inputs); no backpressure, out-of-range writes dropped.
module clock_divider_mc
    import clock_divider_mc_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DIVW        = DIVW_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    clock_divider_mc_if.slave   bus
);

    logic [NCH-1:0] wr_hit;
    logic [NCH-1:0] clk_v;
    logic [NCH-1:0] tick_v;
    logic [NCH-1:0] pend_v;

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            ch_out_t st;

            // Indices >= NCH match no channel, so such writes vanish.
            assign wr_hit[c] = bus.i_wr_en && (int'(bus.i_wr_ch) == c);

            clock_divider_ch #(
                .DIVW        (DIVW),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_en     (bus.i_en[c]),
                .i_sync   (bus.i_sync),
                .i_wr     (wr_hit[c]),
                .i_wr_div (bus.i_wr_div),
                .o_st     (st)
            );

            assign clk_v[c]  = st.clk;
            assign tick_v[c] = st.tick;
            assign pend_v[c] = st.pending;
        end
    endgenerate

    assign bus.o_clk     = clk_v;
    assign bus.o_tick    = tick_v;
    assign bus.o_pending = pend_v;

endmodule

// File: tb/tb_clock_divider_mc.sv
// Self-checking bench for clock_divider_mc: directed scenarios plus random traffic against
// a phase-level reference model (level, countdown to next toggle, active/shadow divisor).
module tb_clock_divider_mc;

    localparam int NCH  = 4;
    localparam int DIVW = 16;
    localparam int DDIV = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    clock_divider_mc_if #(.NCH(NCH), .DIVW(DIVW)) bus  ();
    clock_divider_mc_if #(.NCH(3),   .DIVW(DIVW)) bus3 ();

    clock_divider_mc #(.NCH(NCH), .DIVW(DIVW), .DEFAULT_DIV(DDIV)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    clock_divider_mc #(.NCH(3), .DIVW(DIVW), .DEFAULT_DIV(DDIV)) dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus3)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic m_lvl[NCH];
    logic m_tick[NCH];
    logic m_pend[NCH];
    logic m_fresh[NCH];
    int   m_rem[NCH];
    int   m_act[NCH];
    int   m_shd[NCH];

    function automatic int half_of(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_lvl[c] = 0; m_tick[c] = 0; m_pend[c] = 0; m_fresh[c] = 1;
            m_rem[c] = 0; m_act[c] = DDIV; m_shd[c] = DDIV;
        end
    endtask

    task automatic model_step(input logic [NCH-1:0] en, input logic sync, input logic wr,
                              input int wch, input int wdiv);
        for (int c = 0; c < NCH; c++) begin
            logic hit, busy, falling;
            hit     = wr && (wch == c);
            busy    = en[c] || m_lvl[c];
            falling = 0;
            m_tick[c] = 0;
            if (sync) begin
                if (hit) begin m_act[c] = wdiv; m_shd[c] = wdiv; end
                else if (m_pend[c]) m_act[c] = m_shd[c];
                m_pend[c] = 0; m_lvl[c] = 0; m_fresh[c] = 1;
            end else begin
                if (busy) begin
                    if (m_fresh[c]) begin m_rem[c] = half_of(m_act[c]); m_fresh[c] = 0; end
                    m_rem[c]--;
                    if (m_rem[c] == 0) begin
                        if (m_lvl[c]) falling = 1; else m_tick[c] = 1;
                        m_lvl[c]   = !m_lvl[c];
                        m_fresh[c] = 1;
                    end
                end else begin
                    m_fresh[c] = 1;
                end
                if (hit) begin m_shd[c] = wdiv; m_pend[c] = 1; end
                if (falling || !busy) begin
                    if (m_pend[c]) m_act[c] = m_shd[c];
                    m_pend[c] = 0;
                end
            end
        end
    endtask

    function automatic logic [3*NCH-1:0] exp_vec();
        logic [NCH-1:0] ec, et, ep;
        for (int c = 0; c < NCH; c++) begin
            ec[c] = m_lvl[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
        end
        return {ec, et, ep};
    endfunction

    task automatic tick_clk();
        @(posedge clk);
        model_step(bus.i_en, bus.i_sync, bus.i_wr_en, int'(bus.i_wr_ch), int'(bus.i_wr_div));
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.o_clk, bus.o_tick, bus.o_pending} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_state got %b required 0", {bus.o_clk, bus.o_tick, bus.o_pending});
        end
        n_checks++;
        if ({bus3.o_clk, bus3.o_tick, bus3.o_pending} !== 9'h000) begin
            n_errors++;
            $display("FAIL reset_state3 got %b required 0", {bus3.o_clk, bus3.o_tick, bus3.o_pending});
        end
    endtask

    task automatic test_default_run();
        logic [NCH-1:0] et;
        bus.i_en  = 4'hF;
        bus3.i_en = 3'h7;
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            tick_clk();
            n_checks++;
            if ({bus.o_clk, bus.o_tick, bus.o_pending} !== exp_vec()) begin
                n_errors++;
                $display("FAIL default_run cyc=%0d got %b required %b", cyc,
                         {bus.o_clk, bus.o_tick, bus.o_pending}, exp_vec());
            end
            et = (k >= 2 && (k - 2) % 4 == 0) ? 4'hF : 4'h0;
            n_checks++;
            if (bus.o_tick !== et) begin
                n_errors++;
                $display("FAIL default_tick k=%0d got %b required %b", k, bus.o_tick, et);
            end
        end
    endtask

    task automatic test_bad_ch();
        logic [2:0] ec, et;
        bus3.i_wr_en  = 1'b1;
        bus3.i_wr_ch  = 2'd3;
        bus3.i_wr_div = 16'd9;
        tick_clk();
        bus3.i_wr_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick_clk();
            ec = (cyc >= 2 && (cyc - 2) % 4 < 2) ? 3'h7 : 3'h0;
            et = (cyc >= 2 && (cyc - 2) % 4 == 0) ? 3'h7 : 3'h0;
            n_checks++;
            if ({bus3.o_clk, bus3.o_tick, bus3.o_pending} !== {ec, et, 3'h0}) begin
                n_errors++;
                $display("FAIL bad_ch cyc=%0d got %b required %b", cyc,
                         {bus3.o_clk, bus3.o_tick, bus3.o_pending}, {ec, et, 3'h0});
            end
        end
    endtask

    task automatic test_write_pending();
        logic found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick_clk();
            if (bus.o_tick[1]) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL wr_pend_wait got no tick on ch1 required tick within 20 cycles");
        end
        bus.i_wr_en = 1'b1; bus.i_wr_ch = 2'd1; bus.i_wr_div = 16'd5;
        tick_clk();
        bus.i_wr_en = 1'b0;
        n_checks++;
        if (bus.o_pending[1] !== 1'b1 || bus.o_clk[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_pend_flag got pend=%b clk=%b required pend=1 clk=1",
                     bus.o_pending[1], bus.o_clk[1]);
        end
        for (int k = 0; k < 30; k++) begin
            tick_clk();
            n_checks++;
            if ({bus.o_clk, bus.o_tick, bus.o_pending} !== exp_vec()) begin
                n_errors++;
                $display("FAIL wr_pend_run cyc=%0d got %b required %b", cyc,
                         {bus.o_clk, bus.o_tick, bus.o_pending}, exp_vec());
            end
        end
    endtask

    task automatic test_enable_drop();
        logic found = 0;
        int   k;
        bus.i_wr_en = 1'b1; bus.i_wr_ch = 2'd2; bus.i_wr_div = 16'd3;
        tick_clk();
        bus.i_wr_en = 1'b0;
        // Wait for a rising edge that runs with divisor 3 (after the pending copy).
        for (k = 0; k < 40 && !found; k++) begin
            tick_clk();
            if (bus.o_tick[2] && !bus.o_pending[2] && m_act[2] == 3) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL en_drop_wait got no div3 tick on ch2 required one within 40 cycles");
        end
        tick_clk();
        bus.i_en[2] = 1'b0;
        for (k = 0; k < 12; k++) begin
            tick_clk();
            n_checks++;
            if ({bus.o_clk, bus.o_tick, bus.o_pending} !== exp_vec() || bus.o_tick[2] !== 1'b0) begin
                n_errors++;
                $display("FAIL en_drop_run k=%0d got %b required %b (tick2=0)", k,
                         {bus.o_clk, bus.o_tick, bus.o_pending}, exp_vec());
            end
            if (k == 0 || k == 1) begin
                n_checks++;
                if (bus.o_clk[2] !== (k == 0)) begin
                    n_errors++;
                    $display("FAIL en_drop_fall k=%0d got clk2=%b required %b", k, bus.o_clk[2], k == 0);
                end
            end
        end
        bus.i_en[2] = 1'b1;
        found = 0;
        for (k = 1; k <= 10 && !found; k++) begin
            tick_clk();
            if (bus.o_tick[2]) found = 1;
        end
        n_checks++;
        if (!found || k - 1 != 3) begin
            n_errors++;
            $display("FAIL en_reenable got first tick after %0d cycles required 3", found ? k - 1 : -1);
        end
    endtask

    task automatic test_sync();
        int hh[NCH] = '{3, 4, 7, 2};
        logic [NCH-1:0] et;
        for (int c = 0; c < 3; c++) begin
            bus.i_wr_en = 1'b1; bus.i_wr_ch = 2'(c); bus.i_wr_div = 16'(hh[c]);
            tick_clk();
        end
        bus.i_wr_en = 1'b0;
        repeat ($urandom_range(0, 9)) tick_clk();
        bus.i_sync = 1'b1;
        tick_clk();
        bus.i_sync = 1'b0;
        n_checks++;
        if ({bus.o_clk, bus.o_tick, bus.o_pending} !== 12'h000) begin
            n_errors++;
            $display("FAIL sync_clear got %b required 0", {bus.o_clk, bus.o_tick, bus.o_pending});
        end
        for (int k = 1; k <= 30; k++) begin
            tick_clk();
            for (int c = 0; c < NCH; c++)
                et[c] = (k >= hh[c]) && ((k - hh[c]) % (2 * hh[c]) == 0);
            n_checks++;
            if (bus.o_tick !== et || {bus.o_clk, bus.o_tick, bus.o_pending} !== exp_vec()) begin
                n_errors++;
                $display("FAIL sync_align k=%0d got %b tick=%b required %b tick=%b", k,
                         {bus.o_clk, bus.o_tick, bus.o_pending}, bus.o_tick, exp_vec(), et);
            end
        end
    endtask

    task automatic test_div0();
        logic prev;
        logic done = 0;
        bus.i_wr_en = 1'b1; bus.i_wr_ch = 2'd0; bus.i_wr_div = 16'd0;
        tick_clk();
        bus.i_wr_en = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (!bus.o_pending[0]) done = 1; else tick_clk();
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL div0_apply got pending0=1 required 0 within 20 cycles");
        end
        prev = bus.o_clk[0];
        for (int k = 0; k < 10; k++) begin
            tick_clk();
            n_checks++;
            if (bus.o_clk[0] !== ~prev || {bus.o_clk, bus.o_tick, bus.o_pending} !== exp_vec()) begin
                n_errors++;
                $display("FAIL div0_toggle k=%0d got %b clk0=%b required %b clk0=%b", k,
                         {bus.o_clk, bus.o_tick, bus.o_pending}, bus.o_clk[0], exp_vec(), ~prev);
            end
            prev = bus.o_clk[0];
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) bus.i_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            bus.i_sync  = ($urandom_range(0, 39) == 0);
            bus.i_wr_en = ($urandom_range(0, 5) == 0);
            bus.i_wr_ch = 2'($urandom_range(0, NCH - 1));
            bus.i_wr_div = 16'($urandom_range(0, 6));
            tick_clk();
            n_checks++;
            if ({bus.o_clk, bus.o_tick, bus.o_pending} !== exp_vec()) begin
                n_errors++;
                $display("FAIL random cyc=%0d got %b required %b", cyc,
                         {bus.o_clk, bus.o_tick, bus.o_pending}, exp_vec());
            end
        end
        bus.i_sync = 1'b0;
        bus.i_wr_en = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [NCH-1:0] et;
        bus.i_en = 4'hF;
        bus.i_wr_en = 1'b1; bus.i_wr_ch = 2'd3; bus.i_wr_div = 16'd6;
        tick_clk();
        bus.i_wr_en = 1'b0;
        repeat (3) tick_clk();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_clk, bus.o_tick, bus.o_pending, bus3.o_clk, bus3.o_tick, bus3.o_pending} !== 21'h0) begin
            n_errors++;
            $display("FAIL async_reset got %b/%b required 0", {bus.o_clk, bus.o_tick, bus.o_pending},
                     {bus3.o_clk, bus3.o_tick, bus3.o_pending});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 12; k++) begin
            tick_clk();
            et = (k >= 2 && (k - 2) % 4 == 0) ? 4'hF : 4'h0;
            n_checks++;
            if (bus.o_tick !== et || {bus.o_clk, bus.o_tick, bus.o_pending} !== exp_vec()) begin
                n_errors++;
                $display("FAIL post_reset k=%0d got %b tick=%b required %b tick=%b", k,
                         {bus.o_clk, bus.o_tick, bus.o_pending}, bus.o_tick, exp_vec(), et);
            end
        end
    endtask

    initial begin
        bus.i_en = '0;  bus.i_sync = 1'b0;  bus.i_wr_en = 1'b0;  bus.i_wr_ch = '0;  bus.i_wr_div = '0;
        bus3.i_en = '0; bus3.i_sync = 1'b0; bus3.i_wr_en = 1'b0; bus3.i_wr_ch = '0; bus3.i_wr_div = '0;
        model_reset();
        test_reset();
        test_default_run();
        test_bad_ch();
        test_write_pending();
        test_enable_drop();
        test_sync();
        test_div0();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
